conv_layer_sched: RTL and testbench
===================================

Name: conv_layer_sched

Overview:
Layer scheduler for the streaming conv2d Q1.7 core. It accepts a host command to run N consecutive layers and pulses the core start for each layer. For each layer it counts the core's output write strobes, waits for the core's done pulse, checks the write count against a per-layer configured count, then toggles the ping-pong feature-buffer select. It sits between the host/testbench control and the conv core plus the buffer wrappers.

Parameters:
MAX_LAYERS, 8, depth of the per-layer config table (power of 2)
CNT_W, 20, width of the output-write counter and the expected-count entries
WDT_W, 24, width of the watchdog counter (used only with the optional feature)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
cfg_we  input  1  config write strobe; ignored while busy=1
cfg_addr  input  log2(MAX_LAYERS)  config table index
cfg_wdata  input  CNT_W  expected output writes for that layer (W*H*FILTERS)
cmd_valid  input  1  host run request
cmd_ready  output  1  high only in IDLE
cmd_layers  input  log2(MAX_LAYERS)+1  number of layers to run, 0..MAX_LAYERS
core_start  output  1  one-cycle start pulse to the conv core
core_done  input  1  one-cycle done pulse from the conv core
core_wr  input  1  conv core write_en strobe
layer_idx  output  log2(MAX_LAYERS)  current layer index (drives kernel/bias base select)
buf_sel  output  1  ping-pong select: 0 = read buffer A, write buffer B; 1 = the reverse
busy  output  1  high from command accept until run_done
run_done  output  1  one-cycle pulse at end of run
err  output  1  sticky error flag; cleared on the next command accept
err_code  output  2  0 none, 1 count mismatch, 2 watchdog, 3 reserved

Behaviour:
- Reset values: core_start=0, layer_idx=0, buf_sel=0, busy=0, run_done=0, err=0, err_code=0, cmd_ready=1, state=IDLE. Reset does not clear the config table contents.
- States: IDLE, LAUNCH, WAIT, CHECK, SWAP, FIN. All outputs are registered.
- IDLE: cmd_ready=1.
  - If cmd_valid=1 in cycle t, latch cmd_layers, clear err/err_code and the write counter, set layer_idx=0 and busy=1.
  - If cmd_layers=0, go to FIN. Otherwise go to LAUNCH.
- LAUNCH: core_start=1 for exactly one cycle (cycle t+1 after accept). Clear the write counter. Go to WAIT.
- WAIT:
  - Each cycle with core_wr=1 increments the counter. The counter saturates at all-ones and does not wrap.
  - On core_done=1, go to CHECK. If core_wr and core_done are high in the same cycle, that write is counted.
- CHECK: if counter != cfg[layer_idx], set err=1, err_code=1. The run continues regardless. Go to SWAP.
- SWAP: toggle buf_sel.
  - If layer_idx == latched layers-1, go to FIN.
  - Otherwise increment layer_idx and go to LAUNCH.
- FIN: run_done=1 for one cycle, busy=0, then IDLE. layer_idx and buf_sel hold their final values until the next accept. buf_sel is not reset by a new command, so it carries across runs.
- Per-layer overhead: 4 cycles (LAUNCH, CHECK, SWAP, plus the done cycle).
- core_done or core_wr outside WAIT: ignored, not counted, no error.
- cmd_valid while busy: not accepted (cmd_ready=0), no effect.
- cfg_we in IDLE: writes take effect the next cycle. A write in the same cycle as command accept is honoured.
- rst_n asserted mid-run: immediate return to reset values. No run_done pulse.

Optional Feature:
CONV_SCHED_WDT_EN
- Defined:
  - A WDT_W-bit counter clears on LAUNCH and increments every WAIT cycle.
  - If it reaches all-ones before core_done, set err=1, err_code=2 and go directly to FIN. Remaining layers are skipped and buf_sel is not toggled.
  - A watchdog error overrides an earlier code-1 error.
- Undefined: no watchdog logic. WAIT waits indefinitely for core_done and err_code=2 never occurs.

Test Plan:
- cfg[0]=28672, cmd_layers=1, core model issues 28672 core_wr then core_done -> one core_start pulse at accept+1; run_done pulse; err=0; buf_sel 0->1; busy high throughout.
- cfg[0..2]=4,8,16, cmd_layers=3, model writes matching counts -> 3 core_start pulses; layer_idx 0,1,2; buf_sel ends at 1; err=0.
- cfg[0]=10, model issues 9 writes then done -> err=1, err_code=1, run_done still pulses; next accept clears err to 0.
- cmd_layers=0 -> no core_start; run_done exactly 2 cycles after accept; buf_sel unchanged.
- cmd_valid and core_done asserted while busy and mid-WAIT, then rst_n low for 1 cycle -> second command not accepted; all outputs return to reset values; no run_done pulse.
- With CONV_SCHED_WDT_EN and WDT_W=4, core never signals done -> err_code=2 after 15 WAIT cycles; run_done pulses; later layers not launched.

Source files
------------

// File: rtl/conv_layer_sched_if.sv
// Control bundle between the host/bench, the layer scheduler and the conv core.
// The slave modport is the scheduler and the master modport is its environment.
interface conv_layer_sched_if #(
  parameter int MAX_LAYERS = 8,
  parameter int CNT_W      = 20
) ();
  localparam int AW = $clog2(MAX_LAYERS);

  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [CNT_W-1:0]  cfg_wdata;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [AW:0]       cmd_layers;
  logic              core_start;
  logic              core_done;
  logic              core_wr;
  logic [AW-1:0]     layer_idx;
  logic              buf_sel;
  logic              busy;
  logic              run_done;
  logic              err;
  logic [1:0]        err_code;

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, cmd_valid, cmd_layers, core_done, core_wr,
    output cmd_ready, core_start, layer_idx, buf_sel, busy, run_done, err, err_code
  );

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, cmd_valid, cmd_layers, core_done, core_wr,
    input  cmd_ready, core_start, layer_idx, buf_sel, busy, run_done, err, err_code
  );
endinterface

// File: rtl/conv_layer_sched.sv
// Layer scheduler for the streaming conv2d core: runs N layers back to back,
// counts core writes per layer against a config table and flips the
// ping-pong buffer select after each layer.
// Optional watchdog: define CONV_SCHED_WDT_EN to abort a layer whose core
// never signals done.
module conv_layer_sched #(
  parameter int MAX_LAYERS = 8,
  parameter int CNT_W      = 20,
  parameter int WDT_W      = 24
) (
  input  logic clk,
  input  logic rst_n,
  conv_layer_sched_if.slave bus
);
  localparam int AW = $clog2(MAX_LAYERS);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_WAIT, S_CHECK, S_SWAP, S_FIN
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cfg_mem [MAX_LAYERS];
  logic [CNT_W-1:0]  cfg_rd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [AW:0]       layers_q;
  logic [AW-1:0]     layer_idx_q;
  logic              last_layer;
  logic              core_start_q;
  logic              cmd_ready_q;
  logic              buf_sel_q;
  logic              busy_q;
  logic              run_done_q;
  logic              err_q;
  logic [1:0]        err_code_q;
`ifdef CONV_SCHED_WDT_EN
  logic [WDT_W-1:0]  wdt_q;
  logic [WDT_W-1:0]  wdt_d;
  assign wdt_d = wdt_q + 1'b1;
`endif

  assign cnt_d      = cnt_q + 1'b1;
  assign last_layer = ({1'b0, layer_idx_q} == (layers_q - {{AW{1'b0}}, 1'b1}));

  // Config table: written only while idle, read registered for the current layer.
  // layer_idx is stable from LAUNCH through CHECK, so the read is settled by CHECK.
  always_ff @(posedge clk) begin
    if (bus.cfg_we && !busy_q) cfg_mem[bus.cfg_addr] <= bus.cfg_wdata;
    cfg_rd_q <= cfg_mem[layer_idx_q];
  end

  // Run sequencer with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      layers_q     <= '0;
      layer_idx_q  <= '0;
      core_start_q <= 1'b0;
      cmd_ready_q  <= 1'b1;
      buf_sel_q    <= 1'b0;
      busy_q       <= 1'b0;
      run_done_q   <= 1'b0;
      err_q        <= 1'b0;
      err_code_q   <= 2'd0;
`ifdef CONV_SCHED_WDT_EN
      wdt_q        <= '0;
`endif
    end else begin
      core_start_q <= 1'b0;
      run_done_q   <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            layers_q    <= bus.cmd_layers;
            err_q       <= 1'b0;
            err_code_q  <= 2'd0;
            cnt_q       <= '0;
            layer_idx_q <= '0;
            busy_q      <= 1'b1;
            cmd_ready_q <= 1'b0;
            if (bus.cmd_layers == '0) begin
              state_q <= S_FIN;
            end else begin
              core_start_q <= 1'b1;
              state_q      <= S_LAUNCH;
            end
          end
        end
        S_LAUNCH: begin
          cnt_q   <= '0;
`ifdef CONV_SCHED_WDT_EN
          wdt_q   <= '0;
`endif
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          // A write in the done cycle still belongs to this layer.
          if (bus.core_wr && (cnt_q != '1)) cnt_q <= cnt_d;
          if (bus.core_done) begin
            state_q <= S_CHECK;
          end
`ifdef CONV_SCHED_WDT_EN
          else if (wdt_d == '1) begin
            // Stuck core: abandon the run without swapping buffers.
            err_q      <= 1'b1;
            err_code_q <= 2'd2;
            state_q    <= S_FIN;
          end else begin
            wdt_q <= wdt_d;
          end
`endif
        end
        S_CHECK: begin
          if (cnt_q != cfg_rd_q) begin
            err_q      <= 1'b1;
            err_code_q <= 2'd1;
          end
          state_q <= S_SWAP;
        end
        S_SWAP: begin
          buf_sel_q <= ~buf_sel_q;
          if (last_layer) begin
            state_q <= S_FIN;
          end else begin
            layer_idx_q  <= layer_idx_q + 1'b1;
            core_start_q <= 1'b1;
            state_q      <= S_LAUNCH;
          end
        end
        S_FIN: begin
          run_done_q  <= 1'b1;
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.core_start = core_start_q;
  assign bus.layer_idx  = layer_idx_q;
  assign bus.buf_sel    = buf_sel_q;
  assign bus.busy       = busy_q;
  assign bus.run_done   = run_done_q;
  assign bus.err        = err_q;
  assign bus.err_code   = err_code_q;
endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed bench for conv_layer_sched with a per-run scoreboard and a
// behavioural conv core that issues a planned number of writes per layer.
module tb_conv_layer_sched;
  localparam int ML = 8;
  localparam int CW = 20;
  localparam int WW = 4;
  localparam int AW = $clog2(ML);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_layer_sched_if #(.MAX_LAYERS(ML), .CNT_W(CW)) ifc ();
  conv_layer_sched #(.MAX_LAYERS(ML), .CNT_W(CW), .WDT_W(WW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  logic m_wr = 1'b0, m_done = 1'b0, x_wr = 1'b0, x_done = 1'b0;
  assign ifc.core_wr   = m_wr | x_wr;
  assign ifc.core_done = m_done | x_done;

  typedef struct {
    logic       err;
    logic [1:0] code;
    logic       buf_sel;
    int         starts;
  } run_t;

  run_t sb[$];
  int   plan[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   starts_in_run = 0;
  bit   abort_core = 1'b0;
  bit   m_busy = 1'b0;
  logic exp_buf = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Conv core model: after each start, n write cycles with done on the last
  // (done alone when n=0); n<0 means never finish until aborted.
  initial forever begin
    @(negedge clk);
    if (ifc.core_start === 1'b1 && rst_n === 1'b1) begin
      int n;
      n = (plan.size() > 0) ? plan.pop_front() : 0;
      m_busy = 1'b1;
      if (n < 0) begin
        while (!abort_core) @(negedge clk);
      end else begin
        @(posedge clk); #1;
        for (int i = 1; i <= n && !abort_core; i++) begin
          m_wr = 1'b1;
          m_done = (i == n);
          @(posedge clk); #1;
        end
        if (n == 0 && !abort_core) begin
          m_done = 1'b1;
          @(posedge clk); #1;
        end
        m_wr = 1'b0;
        m_done = 1'b0;
      end
      m_busy = 1'b0;
    end
  end

  // Output monitor: start latency and layer index per launch, run results on run_done.
  initial forever begin
    @(negedge clk);
    if (rst_n === 1'b1) begin
      if (ifc.cmd_valid && ifc.cmd_ready) begin
        acc_cyc = cyc;
        starts_in_run = 0;
      end
      if (ifc.core_start) begin
        if (starts_in_run == 0) chk("start_latency", 32'(cyc - acc_cyc), 32'd1);
        chk("layer_idx", 32'(ifc.layer_idx), 32'(starts_in_run));
        chk("busy_at_start", 32'(ifc.busy), 32'd1);
        starts_in_run++;
      end
      if (ifc.run_done) begin
        if (sb.size() == 0) begin
          chk("unexpected_run_done", 32'd1, 32'd0);
        end else begin
          run_t e;
          e = sb.pop_front();
          chk("run_err", 32'(ifc.err), 32'(e.err));
          chk("run_err_code", 32'(ifc.err_code), 32'(e.code));
          chk("run_buf_sel", 32'(ifc.buf_sel), 32'(e.buf_sel));
          chk("run_starts", 32'(starts_in_run), 32'(e.starts));
          chk("run_busy_low", 32'(ifc.busy), 32'd0);
          $display("run done: layers_started=%0d err=%0d code=%0d buf_sel=%0d",
                   starts_in_run, ifc.err, ifc.err_code, ifc.buf_sel);
        end
      end
    end
  end

  task automatic cfg_write(input int a, input int d);
    ifc.cfg_we = 1'b1;
    ifc.cfg_addr = AW'(a);
    ifc.cfg_wdata = CW'(d);
    @(posedge clk); #1;
    ifc.cfg_we = 1'b0;
  endtask

  task automatic send_cmd(input int n);
    ifc.cmd_valid = 1'b1;
    ifc.cmd_layers = (AW+1)'(n);
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b0;
    ifc.cfg_we = 1'b0;
  endtask

  task automatic expect_run(input logic e, input logic [1:0] c, input int layers);
    run_t r;
    for (int i = 0; i < layers; i++) exp_buf = ~exp_buf;
    r.err = e;
    r.code = c;
    r.buf_sel = exp_buf;
    r.starts = layers;
    sb.push_back(r);
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ifc.cmd_ready && !ifc.busy && !m_busy) begin
        ok = 1'b1;
        break;
      end
    end
    chk("reach_idle", 32'(ok), 32'd1);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_core_start", 32'(ifc.core_start), 32'd0);
    chk("rst_layer_idx", 32'(ifc.layer_idx), 32'd0);
    chk("rst_buf_sel", 32'(ifc.buf_sel), 32'd0);
    chk("rst_busy", 32'(ifc.busy), 32'd0);
    chk("rst_run_done", 32'(ifc.run_done), 32'd0);
    chk("rst_err", 32'(ifc.err), 32'd0);
    chk("rst_err_code", 32'(ifc.err_code), 32'd0);
    chk("rst_cmd_ready", 32'(ifc.cmd_ready), 32'd1);
  endtask

  initial begin
    ifc.cfg_we = 1'b0;
    ifc.cfg_addr = '0;
    ifc.cfg_wdata = '0;
    ifc.cmd_valid = 1'b0;
    ifc.cmd_layers = '0;

    // Reset state
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // One layer, 28672 matching writes
    cfg_write(0, 28672);
    plan.push_back(28672);
    expect_run(1'b0, 2'd0, 1);
    send_cmd(1);
    @(negedge clk);
    chk("t1_busy_after_accept", 32'(ifc.busy), 32'd1);
    chk("t1_cmd_ready_low", 32'(ifc.cmd_ready), 32'd0);
    wait_idle(40000);

    // Three layers; cfg[2] is written in the accept cycle
    cfg_write(0, 4);
    cfg_write(1, 8);
    plan.push_back(4); plan.push_back(8); plan.push_back(16);
    expect_run(1'b0, 2'd0, 3);
    ifc.cfg_we = 1'b1; ifc.cfg_addr = AW'(2); ifc.cfg_wdata = CW'(16);
    send_cmd(3);
    wait_idle(200);
    chk("t2_final_layer_idx", 32'(ifc.layer_idx), 32'd2);

    // Count mismatch: 9 writes against 10 expected
    cfg_write(0, 10);
    plan.push_back(9);
    expect_run(1'b1, 2'd1, 1);
    send_cmd(1);
    wait_idle(200);
    chk("t3_err_sticky", 32'(ifc.err), 32'd1);

    // Zero layers: run_done two cycles after accept, err cleared on accept
    expect_run(1'b0, 2'd0, 0);
    send_cmd(0);
    @(negedge clk);
    chk("t4_err_cleared", 32'(ifc.err), 32'd0);
    chk("t4_run_done_early", 32'(ifc.run_done), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t4_run_done_at_2", 32'(ifc.run_done), 32'd1);
    @(posedge clk); #1;
    wait_idle(20);

    // Busy run: done during LAUNCH, command and cfg write during WAIT, then reset
    plan.push_back(60);
    send_cmd(1);
    x_done = 1'b1; x_wr = 1'b1;
    @(posedge clk); #1;
    x_done = 1'b0; x_wr = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    ifc.cmd_valid = 1'b1; ifc.cmd_layers = '0;
    ifc.cfg_we = 1'b1; ifc.cfg_addr = '0; ifc.cfg_wdata = CW'(5);
    @(negedge clk);
    chk("t5_cmd_ready_busy", 32'(ifc.cmd_ready), 32'd0);
    @(posedge clk); #1;
    ifc.cmd_valid = 1'b0; ifc.cfg_we = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("t5_still_busy", 32'(ifc.busy), 32'd1);
    @(posedge clk); #1;
    abort_core = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_buf = 1'b0;
    repeat (20) begin @(posedge clk); #1; end
    chk("t5_core_model_idle", 32'(m_busy), 32'd0);
    abort_core = 1'b0;
    plan.delete();

    // Config survives reset and the busy write was ignored: 10 writes match
    plan.push_back(10);
    expect_run(1'b0, 2'd0, 1);
    send_cmd(1);
    wait_idle(200);

`ifdef CONV_SCHED_WDT_EN
    // Watchdog: core never finishes, later layers are skipped
    plan.push_back(-1);
    begin
      run_t r;
      r.err = 1'b1; r.code = 2'd2; r.buf_sel = exp_buf; r.starts = 1;
      sb.push_back(r);
    end
    send_cmd(3);
    for (int i = 0; i < 100 && !(ifc.cmd_ready && !ifc.busy); i++) begin
      @(posedge clk); #1;
    end
    abort_core = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    abort_core = 1'b0;
    plan.delete();
    wait_idle(50);
    chk("t6_wdt_code", 32'(ifc.err_code), 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
